// File: rtl/bus_request_arbiter_pkg.sv
// Shared types and constants for the serial-bus request arbiter slice.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_END,
        EVAL,
        RESP
    } state_t;

    localparam logic [1:0] ST_WAIT_TX = 2'd0;
    localparam logic [1:0] ST_WAIT_RX = 2'd1;
    localparam logic [1:0] ST_OK      = 2'd2;
    localparam logic [1:0] ST_CRC     = 2'd3;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_CRC     = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT = 2'd2;

    // Controller statuses 2 and 3 are the two final outcomes of an attempt.
    function automatic logic is_final(input logic [1:0] status);
        return status[1];
    endfunction

endpackage

// File: rtl/bus_request_arbiter_if.sv
// Requester-side and controller-side signals of the bus request arbiter.
interface bus_request_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] cmd_in;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   done;
    logic [7:0]         rsp_data;
    logic [7:0]         rsp_crc;
    logic [1:0]         rsp_code;
    logic               busy;
    logic               ctl_enable;
    logic [7:0]         ctl_cmd;
    logic [1:0]         ctl_status;
    logic [7:0]         ctl_data;
    logic [7:0]         ctl_crc;

    modport master (
        input  req, cmd_in, ctl_status, ctl_data, ctl_crc,
        output grant, done, rsp_data, rsp_crc, rsp_code, busy, ctl_enable, ctl_cmd
    );

    modport slave (
        output req, cmd_in, ctl_status, ctl_data, ctl_crc,
        input  grant, done, rsp_data, rsp_crc, rsp_code, busy, ctl_enable, ctl_cmd
    );
endinterface

// File: rtl/bus_request_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IW-1:0]    win_idx,
    output logic             any
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        winner  = '0;
        win_idx = '0;
        any     = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!any && req[(int'(ptr) + k) % N_REQ]) begin
                any                                 = 1'b1;
                winner[(int'(ptr) + k) % N_REQ]     = 1'b1;
                win_idx                             = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/bus_request_arbiter.sv
// Shares one serial-bus controller among N_REQ requesters: round-robin grant,
// one controller transaction per grant with retry on CRC error or timeout.
module bus_request_arbiter
    import bus_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int TIMEOUT   = 50000,
    parameter int TW        = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    bus_request_arbiter_if.master bus
);

    localparam int IW = $clog2(N_REQ);
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q;
    logic [N_REQ-1:0] grant_q;
    logic [7:0]       ctl_cmd_q;
    logic [RW-1:0]    retry_q;
    logic [TW-1:0]    timer_q;
    logic [1:0]       attempt_q;
    logic [7:0]       cap_data_q, cap_crc_q;
    logic [7:0]       rsp_data_q, rsp_crc_q;
    logic [1:0]       rsp_code_q;

    logic [N_REQ-1:0] winner;
    logic [IW-1:0]    win_idx;
    logic             any_req;
    logic             timer_hit;
    logic             can_retry;
    logic             final_seen;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req     (bus.req),
        .ptr     (ptr_q),
        .winner  (winner),
        .win_idx (win_idx),
        .any     (any_req)
    );

    assign timer_hit  = (timer_q + TW'(1)) == TW'(TIMEOUT);
    assign can_retry  = retry_q < RW'(MAX_RETRY);
    assign final_seen = is_final(bus.ctl_status);

    always_comb begin
        state_d        = state_q;
        bus.ctl_enable = 1'b0;
        bus.done       = '0;
        case (state_q)
            IDLE:       if (any_req) state_d = ISSUE;
            ISSUE: begin
                bus.ctl_enable = 1'b1;
                state_d        = WAIT_START;
            end
            // A status change always beats a timer expiry in the same cycle.
            WAIT_START: begin
                if (!final_seen)    state_d = WAIT_END;
                else if (timer_hit) state_d = EVAL;
            end
            WAIT_END:   if (final_seen || timer_hit) state_d = EVAL;
            EVAL: begin
                if (attempt_q != RSP_OK && can_retry) state_d = ISSUE;
                else                                  state_d = RESP;
            end
            RESP: begin
                bus.done = grant_q;
                state_d  = IDLE;
            end
            default:    state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= IW'(N_REQ - 1);
            grant_q    <= '0;
            ctl_cmd_q  <= '0;
            retry_q    <= '0;
            timer_q    <= '0;
            attempt_q  <= RSP_OK;
            cap_data_q <= '0;
            cap_crc_q  <= '0;
            rsp_data_q <= '0;
            rsp_crc_q  <= '0;
            rsp_code_q <= RSP_OK;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (any_req) begin
                    ptr_q     <= win_idx;
                    grant_q   <= winner;
                    ctl_cmd_q <= bus.cmd_in[int'(win_idx)*8 +: 8];
                    retry_q   <= '0;
                end
                ISSUE: timer_q <= '0;
                WAIT_START: begin
                    timer_q <= timer_q + TW'(1);
                    if (final_seen && timer_hit) attempt_q <= RSP_TIMEOUT;
                end
                WAIT_END: begin
                    timer_q <= timer_q + TW'(1);
                    if (final_seen) begin
                        cap_data_q <= bus.ctl_data;
                        cap_crc_q  <= bus.ctl_crc;
                        attempt_q  <= (bus.ctl_status == ST_OK) ? RSP_OK : RSP_CRC;
                    end else if (timer_hit) begin
                        attempt_q <= RSP_TIMEOUT;
                    end
                end
                EVAL: begin
                    if (state_d == ISSUE) begin
                        retry_q <= retry_q + RW'(1);
                    end else begin
                        rsp_data_q <= cap_data_q;
                        rsp_crc_q  <= cap_crc_q;
                        rsp_code_q <= attempt_q;
                    end
                end
                RESP: grant_q <= '0;
                default: ;
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.busy     = |grant_q;
    assign bus.ctl_cmd  = ctl_cmd_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_crc  = rsp_crc_q;
    assign bus.rsp_code = rsp_code_q;

endmodule

// File: tb/tb_bus_request_arbiter.sv
// Scoreboard bench for bus_request_arbiter with a behavioural serial-bus controller model.
module tb_bus_request_arbiter;
    import bus_pkg::*;

    localparam int N_REQ = 4;

    typedef enum int { MM_NORMAL, MM_HANG, MM_STALL } model_mode_t;

    typedef struct {
        int         idx;
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] crc;
        logic [1:0] code;
        int         enables;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    bus_request_arbiter_if #(.N_REQ(N_REQ)) bus ();

    bus_request_arbiter #(
        .N_REQ     (N_REQ),
        .TIMEOUT   (20),
        .TW        (16),
        .MAX_RETRY (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    int          cycle = 0;
    exp_t        exp_q[$];
    logic [1:0]  script[$];
    model_mode_t model_mode = MM_NORMAL;
    logic [7:0]  m_data = 8'h00;
    logic [7:0]  m_crc  = 8'h00;
    int          fin_cyc = 0;
    int          en_gap  = 0;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [7:0] cmd, input logic [7:0] data,
                            input logic [7:0] crc, input logic [1:0] code, input int enables);
        exp_t e;
        e.idx = idx; e.cmd = cmd; e.data = data; e.crc = crc; e.code = code; e.enables = enables;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (bus.grant != '0) seen = 1'b1;
        end
        if (!seen) check("wait_grant_bound", 0, 1);
    endtask

    task automatic wait_done(input logic [N_REQ-1:0] mask, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if ((bus.done & mask) != '0) seen = 1'b1;
        end
        if (!seen) check("wait_done_bound", 0, 1);
    endtask

    // Controller model: on enable, walks TX -> RX -> scripted final status.
    initial begin
        logic [1:0] fin;
        bus.ctl_status = ST_OK;
        bus.ctl_data   = 8'h00;
        bus.ctl_crc    = 8'h00;
        forever begin
            @(negedge clock);
            if (model_mode == MM_HANG) bus.ctl_status = ST_OK;
            if (bus.ctl_enable && !reset && model_mode != MM_HANG) begin
                bus.ctl_status = ST_WAIT_TX;
                @(negedge clock);
                bus.ctl_status = ST_WAIT_RX;
                if (model_mode == MM_NORMAL) begin
                    @(negedge clock);
                    fin            = (script.size() != 0) ? script.pop_front() : ST_OK;
                    bus.ctl_data   = m_data;
                    bus.ctl_crc    = m_crc;
                    bus.ctl_status = fin;
                    fin_cyc        = cycle;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse.
    initial begin
        int   en_cnt  = 0;
        int   last_en = -1;
        logic prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                en_cnt    = 0;
                prev_done = 1'b0;
            end else begin
                if (prev_done) check("busy_gap_after_done", 32'(bus.busy), 0);
                prev_done = |bus.done;
                if (bus.ctl_enable) begin
                    en_cnt++;
                    if (last_en >= 0) en_gap = cycle - last_en;
                    last_en = cycle;
                end
                if (|bus.done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'(bus.done), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_vector", 32'(bus.done), 32'(1) << e.idx);
                        check("grant_at_done", 32'(bus.grant), 32'(1) << e.idx);
                        check("ctl_cmd", 32'(bus.ctl_cmd), 32'(e.cmd));
                        check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                        check("rsp_crc", 32'(bus.rsp_crc), 32'(e.crc));
                        check("rsp_code", 32'(bus.rsp_code), 32'(e.code));
                        check("enable_pulses", en_cnt, e.enables);
                    end
                    en_cnt = 0;
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        bus.req    = '0;
        bus.cmd_in = '0;
        repeat (3) @(negedge clock);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_enable", 32'(bus.ctl_enable), 0);
        check("rst_ctl_cmd", 32'(bus.ctl_cmd), 0);
        check("rst_rsp_code", 32'(bus.rsp_code), 0);
        reset = 1'b0;
        @(negedge clock);

        // Single clean transaction from requester 0.
        m_data = 8'h3C; m_crc = 8'h91; script = '{ST_OK};
        push_exp(0, 8'hA5, 8'h3C, 8'h91, RSP_OK, 1);
        bus.cmd_in[7:0] = 8'hA5;
        bus.req[0]      = 1'b1;
        wait_grant(10);
        check("t1_grant", 32'(bus.grant), 32'h1);
        check("t1_enable_with_grant", 32'(bus.ctl_enable), 1);
        check("t1_ctl_cmd_latched", 32'(bus.ctl_cmd), 32'hA5);
        wait_done(4'b0001, 50);
        check("t1_done_latency", cycle - fin_cyc, 2);
        bus.req[0] = 1'b0;
        @(negedge clock);

        // Two CRC failures then OK.
        m_data = 8'h5A; m_crc = 8'hC3; script = '{ST_CRC, ST_CRC, ST_OK};
        push_exp(1, 8'h21, 8'h5A, 8'hC3, RSP_OK, 3);
        bus.cmd_in[15:8] = 8'h21;
        bus.req[1]       = 1'b1;
        wait_done(4'b0010, 200);
        bus.req[1] = 1'b0;
        @(negedge clock);

        // Three CRC failures exhaust the retries.
        m_data = 8'h66; m_crc = 8'h99; script = '{ST_CRC, ST_CRC, ST_CRC};
        push_exp(2, 8'h32, 8'h66, 8'h99, RSP_CRC, 3);
        bus.cmd_in[23:16] = 8'h32;
        bus.req[2]        = 1'b1;
        wait_done(4'b0100, 200);
        bus.req[2] = 1'b0;
        @(negedge clock);

        // Controller never leaves stale OK: three timed-out attempts, data from last capture.
        model_mode = MM_HANG;
        push_exp(3, 8'h43, 8'h66, 8'h99, RSP_TIMEOUT, 3);
        bus.cmd_in[31:24] = 8'h43;
        bus.req[3]        = 1'b1;
        wait_done(4'b1000, 300);
        check("to_enable_spacing", en_gap, 22);
        bus.req[3] = 1'b0;
        model_mode = MM_NORMAL;
        @(negedge clock);

        // Reset while the controller is stuck waiting for rx.
        model_mode = MM_STALL;
        bus.req[1] = 1'b1;
        wait_grant(10);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_grant", 32'(bus.grant), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_enable", 32'(bus.ctl_enable), 0);
        check("mid_rst_done", 32'(bus.done), 0);
        check("mid_rst_rsp_code", 32'(bus.rsp_code), 0);
        check("mid_rst_rsp_data", 32'(bus.rsp_data), 0);
        reset      = 1'b0;
        bus.req    = '0;
        model_mode = MM_NORMAL;
        repeat (5) @(negedge clock);

        // All four requesting: order must restart at 0 after reset.
        m_data = 8'h44; m_crc = 8'h55;
        bus.cmd_in = {8'h13, 8'h12, 8'h11, 8'h10};
        push_exp(0, 8'h10, 8'h44, 8'h55, RSP_OK, 1);
        push_exp(1, 8'h11, 8'h44, 8'h55, RSP_OK, 1);
        push_exp(2, 8'h12, 8'h44, 8'h55, RSP_OK, 1);
        push_exp(3, 8'h13, 8'h44, 8'h55, RSP_OK, 1);
        push_exp(0, 8'h10, 8'h44, 8'h55, RSP_OK, 1);
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) wait_done(4'b1111, 50);
        bus.req = '0;
        @(negedge clock);

        // Requester 2 drops req and changes its command after grant.
        push_exp(2, 8'h77, 8'h44, 8'h55, RSP_OK, 1);
        bus.cmd_in[23:16] = 8'h77;
        bus.req[2]        = 1'b1;
        wait_grant(10);
        bus.req[2]        = 1'b0;
        bus.cmd_in[23:16] = 8'h88;
        wait_done(4'b0100, 50);

        repeat (3) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
